// File: rtl/peak_dpu_wb_sb.sv
// Writeback scoreboard: tracks long-latency destination registers from issue to writeback
// and answers RAW/WAW pending queries for the dual-issue dispatch stage.
module peak_dpu_wb_sb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iss0_vld,
    input  logic       iss0_wr_vld,
    input  logic [4:0] iss0_wr_addr,
    input  logic [1:0] iss0_unit,
    input  logic       iss0_long,
    input  logic       iss1_vld,
    input  logic       iss1_wr_vld,
    input  logic [4:0] iss1_wr_addr,
    input  logic [1:0] iss1_unit,
    input  logic       iss1_long,
    input  logic       mul_wb_vld,
    input  logic [4:0] mul_wb_addr,
    input  logic       div_wb_vld,
    input  logic [4:0] div_wb_addr,
    input  logic       lsu_wb_vld,
    input  logic [4:0] lsu_wb_addr,
    input  logic       fp_wb_vld,
    input  logic [4:0] fp_wb_addr,
    input  logic       flush,
    input  logic [4:0] q0_r0_addr,
    input  logic [4:0] q0_r1_addr,
    input  logic [4:0] q1_r0_addr,
    input  logic [4:0] q1_r1_addr,
    input  logic [4:0] q0_wr_addr,
    input  logic [4:0] q1_wr_addr,
    output logic       q0_r0_pend,
    output logic       q0_r1_pend,
    output logic       q1_r0_pend,
    output logic       q1_r1_pend,
    output logic       q0_wr_pend,
    output logic       q1_wr_pend,
    output logic       sb_idle,
    output logic [5:0] sb_cnt,
    output logic       sb_err
);
    typedef enum logic [1:0] {
        UNIT_MUL = 2'd0,
        UNIT_DIV = 2'd1,
        UNIT_LSU = 2'd2,
        UNIT_FP  = 2'd3
    } unit_e;

    logic [31:0]      pend_q, pend_d;
    logic [31:0][1:0] owner_q, owner_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [31:0]      clr;
    logic [31:0]      gone;
    logic [3:0]       wb_vld;
    logic [3:0][4:0]  wb_addr;
    logic             wb_err, set_err;
    logic             set0, set1;

    always_comb begin
        wb_vld  = {fp_wb_vld, lsu_wb_vld, div_wb_vld, mul_wb_vld};
        wb_addr = {fp_wb_addr, lsu_wb_addr, div_wb_addr, mul_wb_addr};
        clr     = '0;
        wb_err  = 1'b0;
        for (int unsigned u = 0; u < 4; u++) begin
            if (wb_vld[u]) begin
                if (pend_q[wb_addr[u]] && owner_q[wb_addr[u]] == 2'(u))
                    clr[wb_addr[u]] = 1'b1;
                else
                    wb_err = 1'b1;
            end
        end
    end

    // Entries leaving this cycle through a writeback or the flush of lsu/fp owners.
    always_comb begin
        gone = clr;
        for (int unsigned r = 1; r < 32; r++) begin
            if (flush && pend_q[r] &&
                (owner_q[r] == UNIT_LSU || owner_q[r] == UNIT_FP))
                gone[r] = 1'b1;
        end
    end

    assign set0 = iss0_vld & iss0_wr_vld & iss0_long & (iss0_wr_addr != 5'd0);
    assign set1 = iss1_vld & iss1_wr_vld & iss1_long & (iss1_wr_addr != 5'd0);

    always_comb begin
        pend_d  = pend_q & ~gone;
        owner_d = owner_q;
        set_err = 1'b0;
        if (set0) begin
            set_err = set_err | (pend_q[iss0_wr_addr] & ~gone[iss0_wr_addr]);
            pend_d[iss0_wr_addr]  = 1'b1;
            owner_d[iss0_wr_addr] = iss0_unit;
        end
        // Slot1 is younger, so its owner overrides slot0 on a shared destination.
        if (set1) begin
            set_err = set_err | (pend_q[iss1_wr_addr] & ~gone[iss1_wr_addr]);
            pend_d[iss1_wr_addr]  = 1'b1;
            owner_d[iss1_wr_addr] = iss1_unit;
        end
        pend_d[0] = 1'b0;
        cnt_d = '0;
        for (int unsigned r = 1; r < 32; r++)
            cnt_d = cnt_d + 6'(pend_d[r]);
        err_d = err_q | wb_err | set_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign q0_r0_pend = pend_q[q0_r0_addr] & ~clr[q0_r0_addr];
    assign q0_r1_pend = pend_q[q0_r1_addr] & ~clr[q0_r1_addr];
    assign q1_r0_pend = pend_q[q1_r0_addr] & ~clr[q1_r0_addr];
    assign q1_r1_pend = pend_q[q1_r1_addr] & ~clr[q1_r1_addr];
    assign q0_wr_pend = pend_q[q0_wr_addr] & ~clr[q0_wr_addr];
    assign q1_wr_pend = pend_q[q1_wr_addr] & ~clr[q1_wr_addr];
    assign sb_cnt     = cnt_q;
    assign sb_idle    = (cnt_q == 6'd0);
    assign sb_err     = err_q;
endmodule

// File: doc/peak_dpu_wb_sb.md
# peak_dpu_wb_sb

Writeback scoreboard for the dual-issue DPU. It records destination registers of long-latency instructions (mul, div, load, fp) at issue and clears them when the owning unit writes back. It returns per-operand pending status to the dispatch control, which uses it for RAW/WAW stall decisions. It is the completion-side counterpart of the dispatch hazard logic.

## Interface
- No parameters: 32 architectural registers; x0 is never tracked.
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- iss0_vld / iss1_vld  in  1  slot0 / slot1 instruction issued this cycle; slot1 is younger
- iss0_wr_vld / iss1_wr_vld  in  1  issued instruction writes rd
- iss0_wr_addr / iss1_wr_addr  in  5  rd
- iss0_unit / iss1_unit  in  2  result unit: 0 mul, 1 div, 2 lsu, 3 fp
- iss0_long / iss1_long  in  1  result is long-latency; ALU/CSR results are not tracked
- mul_wb_vld, div_wb_vld, lsu_wb_vld, fp_wb_vld  in  1  unit writes back this cycle
- mul_wb_addr, div_wb_addr, lsu_wb_addr, fp_wb_addr  in  5  writeback rd
- flush  in  1  pipeline flush; clears all lsu- and fp-owned entries
- q0_r0_addr, q0_r1_addr, q1_r0_addr, q1_r1_addr  in  5  dispatch source queries
- q0_wr_addr, q1_wr_addr  in  5  dispatch destination queries
- q0_r0_pend, q0_r1_pend, q1_r0_pend, q1_r1_pend  out  1  source is pending (RAW)
- q0_wr_pend, q1_wr_pend  out  1  destination is pending (WAW)
- sb_idle  out  1  no entry pending
- sb_cnt  out  6  number of pending entries, range 0..31
- sb_err  out  1  sticky protocol error

## Operation
- State per register 1..31: pend bit and 2-bit owner field.
- Set: an entry is set when iss*_vld & iss*_wr_vld & iss*_long & wr_addr != 0. The entry gets pend=1 and owner=iss*_unit.
- Clear: an entry is cleared when *_wb_vld, wb_addr matches the entry, and the entry owner equals that unit. A writeback to an entry that is not pending, or whose owner differs, changes nothing and sets sb_err.
- Set and clear on the same register in the same cycle: set wins. The new owner is taken from the issue.
- Both slots set the same register: slot1's owner is stored. sb_cnt counts the register once.
- Set on an entry that is already pending and not being cleared this cycle: the entry is overwritten and sb_err is set. Dispatch is required to prevent this (WAW).
- Query: each output is pend[addr] & ~clr_now[addr].
  - The same-cycle writeback is bypassed, so a register whose value is being forwarded reads as not pending.
  - Same-cycle sets are not visible to queries.
  - Address 0 always returns 0.
- flush: clears every entry whose owner is lsu or fp. mul and div entries remain because those units complete.
  - A set in the same cycle as flush still takes effect.
- sb_cnt: popcount of the next-state pend vector, registered. Computed at 6 bits, so it cannot overflow.
- sb_idle = (sb_cnt == 0).
- sb_err is sticky until reset.

## Timing
- Reset (rst_n low, asynchronous): all pend=0, all owner=0, sb_cnt=0, sb_idle=1, sb_err=0. Query outputs go to 0 combinationally.
- Reset mid-operation discards all outstanding entries. Later writebacks to those registers raise sb_err.
- Set latency: issue in cycle N makes the entry visible to queries in N+1.
- Clear latency: 0 for queries (bypass). sb_cnt and sb_idle reflect a clear in cycle N+1.
- Up to 2 sets and 4 clears per cycle, all to independent registers, are supported.
- No handshake: issue and writeback are single-cycle strobes and are never backpressured.

## Test plan
- Reset release, then query x5 -> all *_pend=0, sb_idle=1, sb_cnt=0, sb_err=0.
- Issue slot0 mul to x5 in cycle 1; query x5 in cycle 2 -> q0_r0_pend=1, sb_cnt=1. mul_wb_vld to x5 in cycle 4 -> pend=0 in cycle 4 via bypass, sb_cnt=0 and sb_idle=1 in cycle 5.
- Slot0 div to x7 and slot1 ld to x7 in the same cycle -> owner=lsu, sb_cnt=1. div_wb to x7 -> x7 still pending, sb_err=1. lsu_wb to x7 -> x7 cleared.
- Pending x9 (fp), then fp_wb to x9 and slot0 fp issue to x9 in the same cycle -> x9 pending next cycle, sb_err=0.
- x3 (mul), x4 (lsu) and x6 (fp) pending, then flush -> only x3 remains, sb_cnt=1.
- Issue to x0 with long=1 -> no entry set, sb_cnt unchanged. Issue with long=0 to x8 -> not tracked.
